// File: rtl/rv32_wb_arbiter.sv
// Writeback arbiter: merges in-order results with buffered long-latency results onto the
// single register-file write port and tracks pending long-latency destinations for decode.
// Optional direct late-result path when RV32_WB_BYPASS_EN is defined.
module rv32_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  pipe_rd_in,
    input  logic        pipe_rd_write_in,
    input  logic [31:0] pipe_rd_value_in,
    input  logic        writeback_flush_in,
    input  logic        late_issue_in,
    input  logic [4:0]  late_issue_rd_in,
    input  logic        late_valid_in,
    output logic        late_ready_out,
    input  logic [4:0]  late_rd_in,
    input  logic [31:0] late_value_in,
    input  logic [4:0]  rs1_in,
    input  logic [4:0]  rs2_in,
    input  logic [4:0]  rd_check_in,
    output logic        hazard_stall_out,
    output logic [4:0]  rd_out,
    output logic        rd_write_out,
    output logic [31:0] rd_value_out
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [4:0]       fifo_rd_mem    [DEPTH];
    logic [31:0]      fifo_value_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    logic [31:0] pending_reg;
    logic [31:0] pending_next;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;

    logic [4:0]  rd_reg;
    logic        rd_write_reg;
    logic [31:0] rd_value_reg;
    logic        rd_late_reg;
    logic [4:0]  rd_next;
    logic        rd_write_next;
    logic [31:0] rd_value_next;
    logic        rd_late_next;

    logic inorder_active;
    logic fifo_empty;
    logic late_xfer;
    logic late_keep;
    logic bypass_take;
    logic push;
    logic pop;
    logic issue_ok;

    assign inorder_active = pipe_rd_write_in && !writeback_flush_in && (pipe_rd_in != 5'd0);
    assign fifo_empty     = (count_reg == '0);
    assign late_ready_out = (count_reg != FULL_COUNT);
    assign late_xfer      = late_valid_in && late_ready_out;
    // Results for x0 are consumed at the handshake and never reach the write port.
    assign late_keep      = late_xfer && (late_rd_in != 5'd0);

`ifdef RV32_WB_BYPASS_EN
    assign bypass_take = late_keep && !inorder_active && fifo_empty;
`else
    assign bypass_take = 1'b0;
`endif

    assign pop  = !inorder_active && !fifo_empty;
    assign push = late_keep && !bypass_take;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_reg]    <= late_rd_in;
            fifo_value_mem[wr_ptr_reg] <= late_value_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_comb begin
        rd_next       = 5'd0;
        rd_write_next = 1'b0;
        rd_value_next = 32'd0;
        rd_late_next  = 1'b0;
        if (inorder_active) begin
            rd_next       = pipe_rd_in;
            rd_write_next = 1'b1;
            rd_value_next = pipe_rd_value_in;
        end else if (!fifo_empty) begin
            rd_next       = fifo_rd_mem[rd_ptr_reg];
            rd_write_next = 1'b1;
            rd_value_next = fifo_value_mem[rd_ptr_reg];
            rd_late_next  = 1'b1;
        end else if (bypass_take) begin
            rd_next       = late_rd_in;
            rd_write_next = 1'b1;
            rd_value_next = late_value_in;
            rd_late_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_reg       <= 5'd0;
            rd_write_reg <= 1'b0;
            rd_value_reg <= 32'd0;
            rd_late_reg  <= 1'b0;
        end else begin
            rd_reg       <= rd_next;
            rd_write_reg <= rd_write_next;
            rd_value_reg <= rd_value_next;
            rd_late_reg  <= rd_late_next;
        end
    end

    assign rd_out       = rd_reg;
    assign rd_write_out = rd_write_reg;
    assign rd_value_out = rd_value_reg;

    assign hazard_stall_out = pending_reg[rs1_in] | pending_reg[rs2_in] | pending_reg[rd_check_in]
                            | (late_issue_in && pending_reg[late_issue_rd_in]);
    assign issue_ok = late_issue_in && !hazard_stall_out;

    // A pending bit retires on the edge the register file actually takes the late write.
    assign set_vec = issue_ok ? (32'd1 << late_issue_rd_in) : 32'd0;
    assign clr_vec = rd_late_reg ? (32'd1 << rd_reg) : 32'd0;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_pending
            if (gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_bit
                assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg <= 32'd0;
        end else begin
            pending_reg <= pending_next;
        end
    end

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Self-checking bench for rv32_wb_arbiter: directed vector table, corner sequences and
// randomized traffic against a queue-based model of the writeback port.
module tb_rv32_wb_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  pipe_rd_in;
    logic        pipe_rd_write_in;
    logic [31:0] pipe_rd_value_in;
    logic        writeback_flush_in;
    logic        late_issue_in;
    logic [4:0]  late_issue_rd_in;
    logic        late_valid_in;
    logic        late_ready_out;
    logic [4:0]  late_rd_in;
    logic [31:0] late_value_in;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic [4:0]  rd_check_in;
    logic        hazard_stall_out;
    logic [4:0]  rd_out;
    logic        rd_write_out;
    logic [31:0] rd_value_out;

    rv32_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .pipe_rd_in         (pipe_rd_in),
        .pipe_rd_write_in   (pipe_rd_write_in),
        .pipe_rd_value_in   (pipe_rd_value_in),
        .writeback_flush_in (writeback_flush_in),
        .late_issue_in      (late_issue_in),
        .late_issue_rd_in   (late_issue_rd_in),
        .late_valid_in      (late_valid_in),
        .late_ready_out     (late_ready_out),
        .late_rd_in         (late_rd_in),
        .late_value_in      (late_value_in),
        .rs1_in             (rs1_in),
        .rs2_in             (rs2_in),
        .rd_check_in        (rd_check_in),
        .hazard_stall_out   (hazard_stall_out),
        .rd_out             (rd_out),
        .rd_write_out       (rd_write_out),
        .rd_value_out       (rd_value_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: late results waiting for the port, pending destinations, expected port.
    logic [4:0]  mq_rd  [$];
    logic [31:0] mq_val [$];
    bit          m_pending [32];
    int          m_emit_late_rd;
    logic [4:0]  m_rd;
    logic        m_wr;
    logic [31:0] m_val;

    typedef struct {
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] val;
        logic        flush;
        logic        exp_wr;
        logic [4:0]  exp_rd;
        logic [31:0] exp_val;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq_rd.delete();
        mq_val.delete();
        for (int i = 0; i < 32; i++) m_pending[i] = 1'b0;
        m_emit_late_rd = -1;
        m_rd  = 5'd0;
        m_wr  = 1'b0;
        m_val = 32'd0;
    endtask

    task automatic clear_inputs();
        pipe_rd_in = 0; pipe_rd_write_in = 0; pipe_rd_value_in = 0; writeback_flush_in = 0;
        late_issue_in = 0; late_issue_rd_in = 0; late_valid_in = 0; late_rd_in = 0;
        late_value_in = 0; rs1_in = 0; rs2_in = 0; rd_check_in = 0;
    endtask

    // One clock: check combinational outputs, advance the model, check the registered port.
    task automatic step();
        bit exp_ready, exp_stall, inorder, acc, issue_ok;
        @(negedge clk);
        exp_ready = (mq_rd.size() < DEPTH);
        exp_stall = m_pending[rs1_in] | m_pending[rs2_in] | m_pending[rd_check_in]
                  | (late_issue_in && m_pending[late_issue_rd_in]);
        check("late_ready", late_ready_out, exp_ready);
        check("hazard_stall", hazard_stall_out, exp_stall);
        inorder  = pipe_rd_write_in && !writeback_flush_in && (pipe_rd_in != 0);
        acc      = late_valid_in && exp_ready;
        issue_ok = late_issue_in && !exp_stall;
        if (m_emit_late_rd >= 0) m_pending[m_emit_late_rd] = 1'b0;
        if (issue_ok && late_issue_rd_in != 0) m_pending[late_issue_rd_in] = 1'b1;
        m_emit_late_rd = -1;
`ifdef RV32_WB_BYPASS_EN
        if (acc && late_rd_in != 0) begin
            mq_rd.push_back(late_rd_in);
            mq_val.push_back(late_value_in);
        end
`endif
        if (inorder) begin
            m_wr = 1'b1; m_rd = pipe_rd_in; m_val = pipe_rd_value_in;
        end else if (mq_rd.size() > 0) begin
            m_wr = 1'b1; m_rd = mq_rd.pop_front(); m_val = mq_val.pop_front();
            m_emit_late_rd = m_rd;
        end else begin
            m_wr = 1'b0;
        end
`ifndef RV32_WB_BYPASS_EN
        if (acc && late_rd_in != 0) begin
            mq_rd.push_back(late_rd_in);
            mq_val.push_back(late_value_in);
        end
`endif
        @(posedge clk);
        #1;
        check("rd_write", rd_write_out, m_wr);
        if (m_wr) begin
            check("rd", rd_out, m_rd);
            check("rd_value", rd_value_out, m_val);
            $display("WB t=%0t rd=%0d value=%h late=%0d", $time, m_rd, m_val, m_emit_late_rd >= 0);
        end
    endtask

    initial begin
        logic [4:0] cont_rd [3];
        int idx;
        logic rdy;

        vecs[0] = '{5'd5,  1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{5'd5,  1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0,  32'h0};
        vecs[2] = '{5'd0,  1'b1, 32'h00000123, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[3] = '{5'd31, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 5'd31, 32'hCAFEF00D};
        vecs[4] = '{5'd12, 1'b0, 32'h11111111, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[5] = '{5'd1,  1'b1, 32'h00000001, 1'b0, 1'b1, 5'd1,  32'h00000001};

        clear_inputs();
        reset = 1'b1;
        #2;
        check("reset_rd", rd_out, 0);
        check("reset_write", rd_write_out, 0);
        check("reset_value", rd_value_out, 0);
        check("reset_ready", late_ready_out, 1);
        check("reset_stall", hazard_stall_out, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // In-order slot table
        for (int i = 0; i < 6; i++) begin
            pipe_rd_in = vecs[i].rd; pipe_rd_write_in = vecs[i].wr;
            pipe_rd_value_in = vecs[i].val; writeback_flush_in = vecs[i].flush;
            step();
            check("vec_write", rd_write_out, vecs[i].exp_wr);
            if (vecs[i].exp_wr) begin
                check("vec_rd", rd_out, vecs[i].exp_rd);
                check("vec_value", rd_value_out, vecs[i].exp_val);
            end
            $display("VEC %0d rd=%0d write=%0d flush=%0d", i, vecs[i].rd, vecs[i].wr, vecs[i].flush);
        end
        clear_inputs();
        step();

        // Scoreboard: issue rd=7, then its late result on an idle slot
        late_issue_in = 1; late_issue_rd_in = 7;
        step();
        late_issue_in = 0; rs1_in = 7;
        #1 check("sb_stall_set", hazard_stall_out, 1);
        late_valid_in = 1; late_rd_in = 7; late_value_in = 42;
        step();
        late_valid_in = 0;
`ifndef RV32_WB_BYPASS_EN
        check("sb_not_yet", rd_write_out, 0);
        step();
`endif
        check("sb_emit_rd", rd_out, 7);
        check("sb_emit_write", rd_write_out, 1);
        check("sb_emit_value", rd_value_out, 42);
        check("sb_stall_hold", hazard_stall_out, 1);
        step();
        check("sb_stall_drop", hazard_stall_out, 0);
        rs1_in = 0;

        // Contention: in-order traffic for 4 cycles while rd 1,2,3 offered
        cont_rd[0] = 1; cont_rd[1] = 2; cont_rd[2] = 3;
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            pipe_rd_write_in = (c < 4); pipe_rd_in = 5'(16 + c); pipe_rd_value_in = 32'(c);
            late_valid_in = (idx < 3);
            late_rd_in = (idx < 3) ? cont_rd[idx] : 5'd0;
            late_value_in = 32'h100 + 32'(idx);
            #1 rdy = late_ready_out;
            if (c == 2) check("cont_ready_third", rdy, 0);
            step();
            if (rdy && idx < 3) idx++;
            if (c >= 4) begin
                check("cont_order_rd", rd_out, cont_rd[c-4]);
                check("cont_order_write", rd_write_out, 1);
            end
        end
        clear_inputs();
        step();

        // Set/clear race on rd=9 (no prior issue, so stall stays low for the issue)
        late_valid_in = 1; late_rd_in = 9; late_value_in = 32'h99;
        step();
        late_valid_in = 0;
`ifndef RV32_WB_BYPASS_EN
        step();
`endif
        check("race_emit_rd", rd_out, 9);
        late_issue_in = 1; late_issue_rd_in = 9;
        step();
        late_issue_in = 0; rs1_in = 9;
        #1 check("race_pending9", hazard_stall_out, 1);
        rs1_in = 0;
        late_valid_in = 1; late_rd_in = 9; late_value_in = 32'h9A;
        step();
        late_valid_in = 0;
        repeat (3) step();

        // Zero register
        late_valid_in = 1; late_rd_in = 0; late_value_in = 32'h5555;
        step();
        late_valid_in = 0;
        check("zero_no_write", rd_write_out, 0);
        step();
        check("zero_no_write2", rd_write_out, 0);
        late_issue_in = 1; late_issue_rd_in = 0;
        #1 check("zero_issue_stall", hazard_stall_out, 0);
        step();
        late_issue_in = 0;
        step();

        // Asynchronous reset with two entries queued and a pending destination
        late_issue_in = 1; late_issue_rd_in = 20;
        step();
        late_issue_in = 0;
        pipe_rd_write_in = 1; pipe_rd_in = 4; pipe_rd_value_in = 32'hA;
        late_valid_in = 1; late_rd_in = 3; late_value_in = 32'h33;
        step();
        late_rd_in = 4; late_value_in = 32'h44;
        step();
        late_valid_in = 0; rs1_in = 20;
        @(negedge clk);
        check("pre_reset_full", late_ready_out, 0);
        check("pre_reset_stall", hazard_stall_out, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_reset_rd", rd_out, 0);
        check("mid_reset_write", rd_write_out, 0);
        check("mid_reset_value", rd_value_out, 0);
        check("mid_reset_ready", late_ready_out, 1);
        check("mid_reset_stall", hazard_stall_out, 0);
        clear_inputs();
        rs1_in = 20;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        step();
        rs1_in = 0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            pipe_rd_write_in   = ($urandom_range(0, 2) == 0);
            pipe_rd_in         = 5'($urandom_range(0, 31));
            pipe_rd_value_in   = $urandom;
            writeback_flush_in = ($urandom_range(0, 5) == 0);
            late_issue_in      = ($urandom_range(0, 3) == 0);
            late_issue_rd_in   = 5'($urandom_range(0, 7));
            late_valid_in      = ($urandom_range(0, 1) == 0);
            late_rd_in         = 5'($urandom_range(0, 7));
            late_value_in      = $urandom;
            rs1_in             = 5'($urandom_range(0, 15));
            rs2_in             = 5'($urandom_range(0, 15));
            rd_check_in        = 5'($urandom_range(0, 15));
            step();
        end
        clear_inputs();
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rv32_wb_arbiter.md
# rv32_wb_arbiter

Writeback-side arbiter and scoreboard that owns the single write port of the integer register file. It merges in-order results from the memory stage with out-of-order completions from long-latency units such as a multi-cycle divider, buffering the latter in a small FIFO. It tracks outstanding long-latency destinations and raises a decode stall on RAW/WAW hazards. Outputs are registered and drive the register file's `rd`/`rd_write`/`rd_value` inputs directly.

## Interface
- `DEPTH`, 2, late-result FIFO entries (power of two, ≥2)
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-high reset
- `pipe_rd_in`  in  5  in-order result destination
- `pipe_rd_write_in`  in  1  in-order result writes `pipe_rd_in`
- `pipe_rd_value_in`  in  32  in-order result value
- `writeback_flush_in`  in  1  suppresses this cycle's in-order write
- `late_issue_in`  in  1  decode issues a long-latency op this cycle
- `late_issue_rd_in`  in  5  destination of issued long-latency op
- `late_valid_in`  in  1  long-latency result offered
- `late_ready_out`  out  1  late result accepted when high with `late_valid_in`
- `late_rd_in`  in  5  late result destination
- `late_value_in`  in  32  late result value
- `rs1_in`, `rs2_in`, `rd_check_in`  in  5 each  decode-stage register indices to hazard-check
- `hazard_stall_out`  out  1  decode must stall
- `rd_out`  out  5  register file write index
- `rd_write_out`  out  1  register file write enable
- `rd_value_out`  out  32  register file write data

## Operation
- In-order slot active when `pipe_rd_write_in && !writeback_flush_in && |pipe_rd_in`; it always has priority.
- Late transfer occurs when `late_valid_in && late_ready_out`; `late_ready_out` = FIFO not full (combinational from occupancy only).
- Selection each cycle: in-order slot active → emit it; else FIFO non-empty → emit and pop head; else (bypass, see Configuration) emit accepted late result directly; else `rd_write_out` deasserts.
- Accepted late results with `late_rd_in == 0` are accepted and dropped (never enqueued, never emitted).
- FIFO push and pop in the same cycle allowed at any occupancy except push when full (blocked by ready). Pointers wrap modulo `DEPTH`.
- Scoreboard: 32 pending bits, bit 0 hardwired 0.
  - Set bit `late_issue_rd_in` when `late_issue_in && !hazard_stall_out`.
  - Clear bit `rd_out` on the edge where a late result is emitted.
  - Set and clear same index same edge: set wins.
- `hazard_stall_out` = `pending[rs1_in] | pending[rs2_in] | pending[rd_check_in] | (late_issue_in && pending[late_issue_rd_in])`, combinational.
- `late_issue_in` while `hazard_stall_out` high is ignored.
- Flush never affects FIFO contents or scoreboard: late results belong to committed instructions.

## Timing
- Reset (async): FIFO empty, all pending bits 0, `rd_out`=0, `rd_write_out`=0, `rd_value_out`=0; after reset `late_ready_out`=1, `hazard_stall_out`=0.
- In-order result at edge N appears on `rd_*_out` after edge N, written to register file at edge N+1.
- Late result with bypass, idle slot, empty FIFO: on outputs after accepting edge (1 cycle). Otherwise enqueued; earliest emission one cycle after enqueue.
- Late results emitted in acceptance order; at most one register write per cycle.
- Continuous in-order traffic can starve FIFO indefinitely; `late_ready_out` then stays low once full.
- Reset mid-operation discards FIFO contents and pending bits.

## Configuration
- `RV32_WB_BYPASS_EN` defined: late result accepted with FIFO empty and in-order slot idle goes straight to outputs, not enqueued.
- Undefined: every late result is enqueued; minimum late latency 2 cycles; FIFO push/emission logic otherwise identical.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle with 2 entries queued → outputs 0, `late_ready_out`=1, all pending 0 immediately.
- In-order: `pipe_rd_in`=5, value 0xDEADBEEF, write=1 → next cycle `rd_out`=5, `rd_write_out`=1, `rd_value_out`=0xDEADBEEF; same with flush=1 → `rd_write_out`=0.
- Scoreboard: issue late rd=7, then `rs1_in`=7 → stall=1; late result rd=7 value 42 on idle slot → emitted (1 cycle bypass / 2 without), stall drops the cycle after emission.
- Contention: in-order writes every cycle for 4 cycles while 3 late results offered (rd 1,2,3) → first 2 accepted, `late_ready_out`=0 on third; after traffic stops, rd 1,2,3 emitted in order on consecutive cycles.
- Set/clear race: emit late rd=9 on same edge as a new issue to rd=9 (stall forced off by harness) → pending[9] remains 1.
- Zero register: late result rd=0 accepted → no write emitted; issue with rd=0 → no stall.
